// File: rtl/md_unit_param_if.sv
// rtl/md_unit_param_if.sv - handshake/result bundle between EX stage and the multiply/divide unit
//
// Purpose: groups the op request and HI/LO result signals of md_unit_param.
// Signals:
//   start  op valid this cycle
//   op     4-bit operation code
//   D1     rs operand (dividend / multiplicand / MTxx data)
//   D2     rt operand (divisor / multiplier)
//   busy   operation in flight
//   HI     architectural HI register
//   LO     architectural LO register
//   dz     one-cycle pulse on completion of a divide by zero
// Modports: master drives the request (EX stage), slave is the unit.
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             dz;

  modport master (
    output start, op, D1, D2,
    input  busy, HI, LO, dz
  );

  modport slave (
    input  start, op, D1, D2,
    output busy, HI, LO, dz
  );
endinterface

// File: rtl/md_unit_param.sv
// rtl/md_unit_param.sv - parametrised multiply/divide unit with HI/LO, MADD/MSUB and MTHI/MTLO
//
// Purpose: latches operands on a start op, stays busy for a fixed per-class
//   latency, then commits the result to HI/LO in a single edge. MTHI/MTLO
//   write HI/LO directly with zero latency when idle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    md_unit_param_if.slave: start/op/D1/D2 in, busy/HI/LO/dz out
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic            clk,
  input logic            reset,
  md_unit_param_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CNT_W-1:0]   cnt;
  logic               dz_q;

  logic is_mul_in, is_div_in, accept, mt_hi, mt_lo, commit, is_div_q;

  // Control: decode the incoming op and decide FSM movement.
  always_comb begin
    is_mul_in = 1'b0;
    is_div_in = 1'b0;
    accept    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    commit    = 1'b0;
    state_nx  = state;

    case (bus.op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_in = 1'b1;
      OP_DIV, OP_DIVU:                                         is_div_in = 1'b1;
      default: ;
    endcase

    case (state)
      IDLE: begin
        accept = bus.start && (is_mul_in || is_div_in);
        mt_hi  = bus.start && (bus.op == OP_MTHI);
        mt_lo  = bus.start && (bus.op == OP_MTLO);
        if (accept) state_nx = RUN;
      end
      RUN: begin
        // cnt holds the number of edges left; the last one is the commit edge.
        commit = (cnt == CNT_W'(1));
        if (commit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Multiply/accumulate datapath on the latched operands. Sign-extending to
  // 2*WIDTH and keeping the low 2*WIDTH bits gives the exact signed product.
  logic               signed_mul;
  logic [2*WIDTH-1:0] ea, eb, prod, mul_res;

  always_comb begin
    signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ea   = signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    eb   = signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod = ea * eb;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc_q + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc_q - prod;
      default:           mul_res = prod;
    endcase
  end

  // Divide datapath via magnitudes. The -2^(WIDTH-1) / -1 case falls out as
  // quotient 2^(WIDTH-1) (bit pattern of -2^(WIDTH-1)) with remainder 0.
  // A zero divisor is replaced by 1 only to keep the divider defined; its
  // result is never committed.
  logic             neg_a, neg_b, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b, den, uq, ur, quo, rem;

  always_comb begin
    is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_zero = (b_q == '0);
    neg_a    = (op_q == OP_DIV) && a_q[WIDTH-1];
    neg_b    = (op_q == OP_DIV) && b_q[WIDTH-1];
    mag_a    = neg_a ? -a_q : a_q;
    mag_b    = neg_b ? -b_q : b_q;
    den      = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    uq       = mag_a / den;
    ur       = mag_a % den;
    quo      = (neg_a ^ neg_b) ? -uq : uq;
    rem      = neg_a ? -ur : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      dz_q <= 1'b0;
      if (accept) begin
        op_q  <= bus.op;
        a_q   <= bus.D1;
        b_q   <= bus.D2;
        acc_q <= {hi_q, lo_q};
        cnt   <= is_div_in ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
        if (commit) begin
          if (is_div_q) begin
            if (div_zero) begin
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end else begin
            {hi_q, lo_q} <= mul_res;
          end
        end
      end
      if (mt_hi) hi_q <= bus.D1;
      if (mt_lo) lo_q <= bus.D1;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_md_unit_param.sv
// tb/tb_md_unit_param.sv - directed scoreboard bench for md_unit_param
//
// Purpose: drives directed and model-driven ops through the unit, pushes the
//   expected HI/LO/dz to a queue at issue and pops it when the unit commits.
// Ports: none (top-level bench).
module tb_md_unit_param;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [31:0] m_hi, m_lo;

  md_unit_param_if #(.WIDTH(32)) bus();

  md_unit_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit native arithmetic on {hi,lo}.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [63:0] acc);
    longint sa, sb_v, q, r;
    logic [63:0] p, res, ud1, ud2, uq, ur;
    sa   = longint'($signed(d1));
    sb_v = longint'($signed(d2));
    ud1  = {32'b0, d1};
    ud2  = {32'b0, d2};
    p    = 64'd0;
    res  = acc;
    case (op)
      4'd1, 4'd7, 4'd9:  p = sa * sb_v;
      4'd2, 4'd8, 4'd10: p = ud1 * ud2;
      default: ;
    endcase
    case (op)
      4'd1, 4'd2: res = p;
      4'd7, 4'd8: res = acc + p;
      4'd9, 4'd10: res = acc - p;
      4'd3: if (d2 != 0) begin
        q = sa / sb_v;
        r = sa % sb_v;
        res = {r[31:0], q[31:0]};
      end
      4'd4: if (d2 != 0) begin
        uq = ud1 / ud2;
        ur = ud1 % ud2;
        res = {ur[31:0], uq[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
      chk({tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
      chk({tag, "_dz"}, 64'(bus.dz), 64'(e.dz));
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  // Zero-latency op (MTHI/MTLO/NOP), driven and checked at negedges.
  task automatic run_short(input string tag, input logic [3:0] op, input logic [31:0] d,
                           input logic [31:0] ehi, input logic [31:0] elo);
    push(ehi, elo, 1'b0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.D1    = d;
    bus.D2    = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    pop_check(tag);
  endtask

  // Multi-cycle op with an optional op injected while busy (inj_at < 0: none).
  task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int inj_at, input logic [3:0] inj_op, input logic [31:0] inj_d);
    int cyc;
    push(ehi, elo, edz);
    bus.start = 1'b1;
    bus.op    = op;
    bus.D1    = d1;
    bus.D2    = d2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < lat + 20) begin
      chk({tag, "_hold_hi"}, 64'(bus.HI), 64'(m_hi));
      chk({tag, "_hold_lo"}, 64'(bus.LO), 64'(m_lo));
      if (cyc == inj_at) begin
        bus.start = 1'b1;
        bus.op    = inj_op;
        bus.D1    = inj_d;
        bus.D2    = inj_d;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    pop_check(tag);
    @(negedge clk);
    chk({tag, "_dz_pulse_end"}, 64'(bus.dz), 64'd0);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] res;
    int          lat;
    logic [3:0]  ops [8];

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.op = 4'd0;
    bus.D1 = 32'h0;
    bus.D2 = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    chk("rst_dz", 64'(bus.dz), 64'd0);

    // Reset wins over a start in the same cycle.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.op = 4'd1;
    bus.D1 = 32'd3;
    bus.D2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_vs_start_busy", 64'(bus.busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("rst_vs_start_lo", 64'(bus.LO), 64'd0);

    // Signed divide -6 / -3.
    run_long("div_neg", 4'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 10, 32'd0, 32'd2, 1'b0, -1, 4'd0, 32'd0);

    // Signed and unsigned multiply of 0xFFFFFFFF by 2.
    run_long("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -1, 4'd0, 32'd0);
    run_long("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, -1, 4'd0, 32'd0);

    // MTHI/MTLO then accumulate.
    run_short("mthi0", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFE);
    run_short("mtlo10", 4'd6, 32'd10, 32'd0, 32'd10);
    run_long("madd", 4'd7, 32'd3, 32'd4, 5, 32'd0, 32'd22, 1'b0, -1, 4'd0, 32'd0);
    run_long("msub", 4'd9, 32'd5, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, 4'd0, 32'd0);

    // Divide by zero leaves HI/LO, pulses dz; signed overflow policy.
    run_short("mthi7", 4'd5, 32'd7, 32'd7, 32'hFFFF_FFFD);
    run_short("mtlo9", 4'd6, 32'd9, 32'd7, 32'd9);
    run_long("div_zero", 4'd3, 32'd5, 32'd0, 10, 32'd7, 32'd9, 1'b1, -1, 4'd0, 32'd0);
    run_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0, -1, 4'd0, 32'd0);
    run_long("divu_zero", 4'd4, 32'd123, 32'd0, 10, 32'd0, 32'h8000_0000, 1'b1, -1, 4'd0, 32'd0);

    // Start while busy is ignored, including MTHI.
    run_long("divu_inj_mult", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 2, 4'd1, 32'd9);
    run_long("divu_inj_mthi", 4'd4, 32'd1000, 32'd33, 10, 32'd10, 32'd30, 1'b0, 4, 4'd5, 32'hDEAD);

    // NOP and undefined codes change nothing.
    run_short("nop0", 4'd0, 32'h1234, 32'd10, 32'd30);
    run_short("nop13", 4'd13, 32'h5678, 32'd10, 32'd30);

    // Model-driven ops over random operands.
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    for (int i = 0; i < 10; i++) begin
      rop = ops[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = (i == 3) ? 32'hFFFF_FFF9 : $urandom;
      if (i == 5) ra = 32'hFFFF_FF00;
      res = model(rop, ra, rb, {m_hi, m_lo});
      lat = (rop == 4'd3 || rop == 4'd4) ? 10 : 5;
      run_long("rand", rop, ra, rb, lat, res[63:32], res[31:0], 1'b0, -1, 4'd0, 32'd0);
    end

    // Reset in the middle of a multiply discards it.
    run_short("mthi55", 4'd5, 32'h55, 32'h55, m_lo);
    bus.start = 1'b1;
    bus.op = 4'd1;
    bus.D1 = 32'd3;
    bus.D2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hi", 64'(bus.HI), 64'd0);
    chk("midrst_lo", 64'(bus.LO), 64'd0);
    repeat (6) @(negedge clk);
    chk("midrst_no_commit_hi", 64'(bus.HI), 64'd0);
    chk("midrst_no_commit_lo", 64'(bus.LO), 64'd0);
    chk("midrst_no_commit_busy", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
